y_stat_collector: RTL

Downstream statistics stage for the 2-bit `y` output of the serial-input FSM (`source`). It samples `y` on every enabled clock edge and keeps the following statistics:
- saturating per-code occurrence counters;
- the current run length and the last code;
- the longest run seen and the code of that run;
- a one-cycle change pulse.

Software or a bench reads the counters through a select port. All state is cleared by reset or by a synchronous clear.

---
 rtl/y_stat_collector.sv | 109 ++++++++++
 1 files changed

// File: rtl/y_stat_collector.sv
// Occurrence, run-length and change statistics on the sampled 2-bit y code; updates visible right after the sampling edge.
// No backpressure: en qualifies each sample, cnt is a zero-latency mux of the counters selected by sel.
module y_stat_collector #(
   parameter int CNT_W = 8,
   parameter int RUN_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       y,
   input  logic             en,
   input  logic             clr,
   input  logic [1:0]       sel,
   output logic [CNT_W-1:0] cnt,
   output logic [1:0]       last_y,
   output logic [RUN_W-1:0] run_len,
   output logic [RUN_W-1:0] max_run,
   output logic [1:0]       max_code,
   output logic             change,
   output logic             sat
);

   typedef enum logic {S_EMPTY, S_TRACK} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [RUN_W-1:0] RUN_MAX = '1;

   state_t           state_q,    state_d;
   logic [CNT_W-1:0] cnt_q [4];
   logic [CNT_W-1:0] cnt_d [4];
   logic [1:0]       last_y_q,   last_y_d;
   logic [RUN_W-1:0] run_len_q,  run_len_d;
   logic [RUN_W-1:0] max_run_q,  max_run_d;
   logic [1:0]       max_code_q, max_code_d;
   logic             change_q,   change_d;
   logic             sat_q,      sat_d;
   logic [RUN_W-1:0] run_new;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      last_y_d   = last_y_q;
      run_len_d  = run_len_q;
      max_run_d  = max_run_q;
      max_code_d = max_code_q;
      change_d   = 1'b0;
      sat_d      = sat_q;
      run_new    = RUN_W'(1);

      if (clr) begin
         state_d = S_EMPTY;
         for (int i = 0; i < 4; i++) cnt_d[i] = '0;
         last_y_d   = '0;
         run_len_d  = '0;
         max_run_d  = '0;
         max_code_d = '0;
         sat_d      = 1'b0;
      end else if (en) begin
         if (cnt_q[y] != CNT_MAX) cnt_d[y] = cnt_q[y] + CNT_W'(1);
         if (cnt_d[y] == CNT_MAX) sat_d = 1'b1;

         // A matching code only extends the run once a valid previous sample exists
         if (state_q == S_TRACK && y == last_y_q) begin
            run_new = (run_len_q == RUN_MAX) ? run_len_q : run_len_q + RUN_W'(1);
         end else begin
            run_new  = RUN_W'(1);
            change_d = (state_q == S_TRACK);
         end

         state_d   = S_TRACK;
         last_y_d  = y;
         run_len_d = run_new;
         if (run_new > max_run_q) begin
            max_run_d  = run_new;
            max_code_d = y;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_EMPTY;
         for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
         last_y_q   <= '0;
         run_len_q  <= '0;
         max_run_q  <= '0;
         max_code_q <= '0;
         change_q   <= 1'b0;
         sat_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         last_y_q   <= last_y_d;
         run_len_q  <= run_len_d;
         max_run_q  <= max_run_d;
         max_code_q <= max_code_d;
         change_q   <= change_d;
         sat_q      <= sat_d;
      end
   end

   assign cnt      = cnt_q[sel];
   assign last_y   = last_y_q;
   assign run_len  = run_len_q;
   assign max_run  = max_run_q;
   assign max_code = max_code_q;
   assign change   = change_q;
   assign sat      = sat_q;

endmodule
